// File: rtl/button_ctrl_if.sv
// Event handshake bundle between button_ctrl and its consumer.
// The master drives the event register and drop pulse; the slave returns ready.
interface button_ctrl_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [2:0] ev_btn;
    logic [1:0] ev_kind;
    logic       ev_drop;

    modport master (output ev_valid, ev_btn, ev_kind, ev_drop, input ev_ready);
    modport slave  (input ev_valid, ev_btn, ev_kind, ev_drop, output ev_ready);
endinterface

// File: rtl/button_ctrl.sv
// Per-button short/long/repeat press classifier with one pending slot per button and a
// round-robin event output register. Define BUTTON_CTRL_REPEAT_EN to enable auto-repeat.
module button_fsm #(
    parameter int LONG_CNT   = 100,
    parameter int REPEAT_CNT = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    output logic       ev,
    output logic [1:0] ev_kind
);
    typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

    localparam logic [1:0]  KIND_SHORT = 2'd0;
    localparam logic [1:0]  KIND_LONG  = 2'd1;
    localparam logic [15:0] LONG_LAST  = 16'(LONG_CNT - 1);
`ifdef BUTTON_CTRL_REPEAT_EN
    localparam logic [1:0]  KIND_REPEAT = 2'd2;
    localparam logic [15:0] REP_LAST    = 16'(REPEAT_CNT - 1);
`endif

    if (LONG_CNT < 2 || LONG_CNT > 65535 || REPEAT_CNT < 2 || REPEAT_CNT > 65535) begin : g_param_chk
        $error("button_fsm: LONG_CNT/REPEAT_CNT must be in 2..65535");
    end

    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic        btn_q;

    // btn_q resets high so a button held through reset is not seen as a new press
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            btn_q <= 1'b1;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            btn_q <= btn;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ev       = 1'b0;
        ev_kind  = KIND_SHORT;
        case (state)
            IDLE: begin
                if (btn && !btn_q) begin
                    state_nx = PRESSED;
                    cnt_nx   = '0;
                end
            end
            PRESSED: begin
                if (!btn) begin
                    ev       = 1'b1;
                    ev_kind  = KIND_SHORT;
                    state_nx = IDLE;
                end else if (cnt == LONG_LAST) begin
                    ev       = 1'b1;
                    ev_kind  = KIND_LONG;
                    state_nx = HELD;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            HELD: begin
                if (!btn) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
`ifdef BUTTON_CTRL_REPEAT_EN
                    if (cnt == REP_LAST) begin
                        ev      = 1'b1;
                        ev_kind = KIND_REPEAT;
                        cnt_nx  = '0;
                    end else begin
                        cnt_nx = cnt + 16'd1;
                    end
`else
                    cnt_nx = '0;
`endif
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

module button_ctrl #(
    parameter int N_BTN      = 4,
    parameter int LONG_CNT   = 100,
    parameter int REPEAT_CNT = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_db,
    button_ctrl_if.master    ev
);
    localparam int IW = $clog2(N_BTN);

    typedef struct packed {
        logic       vld;
        logic [1:0] kind;
    } slot_t;

    logic [N_BTN-1:0]       raise;
    logic [N_BTN-1:0][1:0]  raise_kind;
    slot_t [N_BTN-1:0]      slot;
    logic [N_BTN-1:0]       pend;
    logic [IW-1:0]          rr_ptr;
    logic [IW-1:0]          gnt_idx;
    logic [IW:0]            rr_idx;
    logic                   gnt_any;
    logic                   load;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        button_fsm #(.LONG_CNT(LONG_CNT), .REPEAT_CNT(REPEAT_CNT)) u_fsm (
            .clk     (clk),
            .rst_n   (rst_n),
            .btn     (btn_db[i]),
            .ev      (raise[i]),
            .ev_kind (raise_kind[i])
        );
        assign pend[i] = slot[i].vld;
    end

    assign load = !ev.ev_valid || ev.ev_ready;

    // first pending slot scanning upward from rr_ptr, wrapping at N_BTN
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        rr_idx  = '0;
        for (int k = 0; k < N_BTN; k++) begin
            rr_idx = {1'b0, rr_ptr} + (IW+1)'(k);
            if (rr_idx >= (IW+1)'(N_BTN))
                rr_idx = rr_idx - (IW+1)'(N_BTN);
            if (!gnt_any && pend[rr_idx[IW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = rr_idx[IW-1:0];
            end
        end
    end

    // grant reads the pre-edge slot, so a slot can't be set and granted on one edge
    always_ff @(posedge clk) begin
        if (rst_n) begin
            slot        <= '0;
            rr_ptr      <= '0;
            ev.ev_valid <= 1'b0;
            ev.ev_btn   <= '0;
            ev.ev_kind  <= '0;
            ev.ev_drop  <= 1'b0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (load && gnt_any && gnt_idx == IW'(i))
                    slot[i].vld <= 1'b0;
                else if (raise[i] && !slot[i].vld)
                    slot[i] <= '{vld: 1'b1, kind: raise_kind[i]};
            end
            ev.ev_drop <= |(raise & pend);
            if (load) begin
                ev.ev_valid <= gnt_any;
                if (gnt_any) begin
                    ev.ev_btn  <= 3'(gnt_idx);
                    ev.ev_kind <= slot[gnt_idx].kind;
                    rr_ptr     <= (gnt_idx == IW'(N_BTN - 1)) ? '0 : gnt_idx + IW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_button_ctrl.sv
// Randomized and directed bench for button_ctrl against a run-length based event model.
module tb_button_ctrl;
    localparam int NB   = 4;
    localparam int LONG = 100;
    localparam int REP  = 25;
`ifdef BUTTON_CTRL_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [NB-1:0] btn;
    button_ctrl_if bif ();

    button_ctrl #(.N_BTN(NB), .LONG_CNT(LONG), .REPEAT_CNT(REP)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_db (btn),
        .ev     (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // model: press run lengths, pending slots, output register
    bit         m_prev [NB];
    bit         m_armed[NB];
    int         m_run  [NB];
    bit         m_pend [NB];
    logic [1:0] m_pkind[NB];
    bit         m_valid, m_drop;
    logic [2:0] m_btn;
    logic [1:0] m_kind;
    int         m_rr;

    task automatic tick();
        bit         evv [NB];
        logic [1:0] evk [NB];
        bit         oldp[NB];
        int         g, j;
        if (rst_n) begin
            for (int i = 0; i < NB; i++) begin
                m_prev[i] = 1; m_armed[i] = 0; m_run[i] = 0; m_pend[i] = 0; m_pkind[i] = 0;
            end
            m_valid = 0; m_btn = 0; m_kind = 0; m_drop = 0; m_rr = 0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                evv[i] = 0; evk[i] = 0;
                if (btn[i]) begin
                    if (!m_prev[i]) begin m_armed[i] = 1; m_run[i] = 0; end
                    if (m_armed[i]) begin
                        m_run[i]++;
                        if (m_run[i] == LONG + 1) begin evv[i] = 1; evk[i] = 2'd1; end
                        else if (REP_EN && m_run[i] > LONG + 1 && (m_run[i] - LONG - 1) % REP == 0) begin
                            evv[i] = 1; evk[i] = 2'd2;
                        end
                    end
                end else begin
                    if (m_armed[i] && m_run[i] <= LONG) begin evv[i] = 1; evk[i] = 2'd0; end
                    m_armed[i] = 0;
                end
                m_prev[i] = btn[i];
            end
            oldp = m_pend;
            g = -1;
            if (!m_valid || bif.ev_ready) begin
                for (int k = 0; k < NB; k++) begin
                    j = (m_rr + k) % NB;
                    if (g < 0 && oldp[j]) g = j;
                end
                if (g >= 0) begin
                    m_valid = 1; m_btn = 3'(g); m_kind = m_pkind[g]; m_pend[g] = 0; m_rr = (g + 1) % NB;
                end else m_valid = 0;
            end
            m_drop = 0;
            for (int i = 0; i < NB; i++)
                if (evv[i]) begin
                    if (oldp[i]) m_drop = 1;
                    else begin m_pend[i] = 1; m_pkind[i] = evk[i]; end
                end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1; btn = '0; bif.ev_ready = 0;
        repeat (3) tick();
        if (bif.ev_valid !== 1'b0 || bif.ev_btn !== 3'd0 || bif.ev_kind !== 2'd0 || bif.ev_drop !== 1'b0) begin
            errors++;
            $display("FAIL reset: got v=%b b=%0d k=%0d d=%b want all 0", bif.ev_valid, bif.ev_btn, bif.ev_kind, bif.ev_drop);
        end
        checks++;
        rst_n = 0;
        tick();
    endtask

    task automatic test_short();
        int first = -1, nev = 0;
        bif.ev_ready = 1;
        btn[0] = 1;
        for (int k = 1; k <= 16; k++) begin
            if (k == 11) btn[0] = 0;
            tick();
            if (bif.ev_valid !== m_valid || bif.ev_drop !== m_drop || (m_valid && (bif.ev_btn !== m_btn || bif.ev_kind !== m_kind))) begin
                errors++;
                $display("FAIL short_model t=%0t got v=%b b=%0d k=%0d d=%b want v=%b b=%0d k=%0d d=%b", $time, bif.ev_valid, bif.ev_btn, bif.ev_kind, bif.ev_drop, m_valid, m_btn, m_kind, m_drop);
            end
            checks++;
            if (bif.ev_valid === 1'b1) begin
                nev++;
                if (first < 0) first = k - 10;
            end
        end
        if (first !== 2 || nev !== 1) begin
            errors++;
            $display("FAIL short_latency: got first=%0d count=%0d want first=2 count=1", first, nev);
        end
        checks++;
    endtask

    task automatic test_long();
        int det[$];
        int dk[$];
        int exp_det[$];
        int exp_k[$];
        int nrel = 0;
        if (REP_EN) begin exp_det = '{100, 125, 150}; exp_k = '{1, 2, 2}; end
        else begin exp_det = '{100}; exp_k = '{1}; end
        bif.ev_ready = 1;
        btn[1] = 1;
        for (int h = 0; h < 165; h++) begin
            if (h == 160) btn[1] = 0;
            tick();
            if (bif.ev_valid !== m_valid || bif.ev_drop !== m_drop || (m_valid && (bif.ev_btn !== m_btn || bif.ev_kind !== m_kind))) begin
                errors++;
                $display("FAIL long_model t=%0t got v=%b b=%0d k=%0d d=%b want v=%b b=%0d k=%0d d=%b", $time, bif.ev_valid, bif.ev_btn, bif.ev_kind, bif.ev_drop, m_valid, m_btn, m_kind, m_drop);
            end
            checks++;
            if (bif.ev_valid === 1'b1) begin
                if (h >= 160) nrel++;
                else begin det.push_back(h - 1); dk.push_back(int'(bif.ev_kind)); end
            end
        end
        if (det.size() != exp_det.size() || nrel != 0) begin
            errors++;
            $display("FAIL long_count: got %0d events (+%0d on release) want %0d (+0)", det.size(), nrel, exp_det.size());
        end
        checks++;
        for (int i = 0; i < det.size() && i < exp_det.size(); i++) begin
            if (det[i] != exp_det[i] || dk[i] != exp_k[i]) begin
                errors++;
                $display("FAIL long_event%0d: got cycle=%0d kind=%0d want cycle=%0d kind=%0d", i, det[i], dk[i], exp_det[i], exp_k[i]);
            end
            checks++;
        end
    endtask

    task automatic test_round_robin();
        int seq[$];
        int at[$];
        rst_n = 1; btn = '0; tick();
        rst_n = 0; tick();
        bif.ev_ready = 1;
        for (int rep = 0; rep < 2; rep++) begin
            seq.delete(); at.delete();
            btn = 4'b1101;
            for (int k = 0; k < 11; k++) begin
                if (k == 3) btn = '0;
                tick();
                if (bif.ev_valid !== m_valid || bif.ev_drop !== m_drop || (m_valid && (bif.ev_btn !== m_btn || bif.ev_kind !== m_kind))) begin
                    errors++;
                    $display("FAIL rr_model t=%0t got v=%b b=%0d k=%0d d=%b want v=%b b=%0d k=%0d d=%b", $time, bif.ev_valid, bif.ev_btn, bif.ev_kind, bif.ev_drop, m_valid, m_btn, m_kind, m_drop);
                end
                checks++;
                if (bif.ev_valid === 1'b1) begin seq.push_back(int'(bif.ev_btn)); at.push_back(k); end
            end
            if (seq.size() != 3 || seq[0] != 0 || seq[1] != 2 || seq[2] != 3 || at[1] != at[0] + 1 || at[2] != at[1] + 1) begin
                errors++;
                $display("FAIL rr_order%0d: got %0d events %p at %p want 0,2,3 consecutive", rep, seq.size(), seq, at);
            end
            checks++;
        end
    endtask

    task automatic test_backpressure();
        int  drops = 0, nacc = 0;
        bit  seen = 0;
        rst_n = 1; btn = '0; tick();
        rst_n = 0; bif.ev_ready = 0; tick();
        for (int k = 0; k < 18; k++) begin
            btn[1] = ((k % 6) < 3);
            tick();
            if (bif.ev_valid !== m_valid || bif.ev_drop !== m_drop || (m_valid && (bif.ev_btn !== m_btn || bif.ev_kind !== m_kind))) begin
                errors++;
                $display("FAIL bp_model t=%0t got v=%b b=%0d k=%0d d=%b want v=%b b=%0d k=%0d d=%b", $time, bif.ev_valid, bif.ev_btn, bif.ev_kind, bif.ev_drop, m_valid, m_btn, m_kind, m_drop);
            end
            checks++;
            if (bif.ev_drop === 1'b1) drops++;
            if (seen) begin
                if (bif.ev_valid !== 1'b1 || bif.ev_btn !== 3'd1 || bif.ev_kind !== 2'd0) begin
                    errors++;
                    $display("FAIL bp_stable: got v=%b b=%0d k=%0d want v=1 b=1 k=0", bif.ev_valid, bif.ev_btn, bif.ev_kind);
                end
                checks++;
            end
            if (bif.ev_valid === 1'b1) seen = 1;
        end
        btn[1] = 0;
        if (drops != 1) begin
            errors++;
            $display("FAIL bp_drop: got %0d drop pulses want 1", drops);
        end
        checks++;
        bif.ev_ready = 1;
        for (int k = 0; k < 6; k++) begin
            if (bif.ev_valid === 1'b1) nacc++;
            tick();
            if (bif.ev_valid !== m_valid || bif.ev_drop !== m_drop || (m_valid && (bif.ev_btn !== m_btn || bif.ev_kind !== m_kind))) begin
                errors++;
                $display("FAIL bp_drain t=%0t got v=%b b=%0d k=%0d want v=%b b=%0d k=%0d", $time, bif.ev_valid, bif.ev_btn, bif.ev_kind, m_valid, m_btn, m_kind);
            end
            checks++;
        end
        if (nacc != 2) begin
            errors++;
            $display("FAIL bp_accept: got %0d accepted events want 2", nacc);
        end
        checks++;
    endtask

    task automatic test_reset_hold();
        int nev = 0, nev2 = 0;
        bit good = 1;
        bif.ev_ready = 1; btn = '0;
        btn[2] = 1;
        repeat (3) tick();
        rst_n = 1; repeat (2) tick();
        rst_n = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (bif.ev_valid !== m_valid || bif.ev_drop !== m_drop) begin
                errors++;
                $display("FAIL hold_model t=%0t got v=%b d=%b want v=%b d=%b", $time, bif.ev_valid, bif.ev_drop, m_valid, m_drop);
            end
            checks++;
            if (bif.ev_valid === 1'b1 || bif.ev_drop === 1'b1) nev++;
        end
        if (nev != 0) begin
            errors++;
            $display("FAIL hold_through_reset: got %0d event cycles want 0", nev);
        end
        checks++;
        btn[2] = 0; tick();
        for (int k = 0; k < 12; k++) begin
            btn[2] = (k < 5);
            tick();
            if (bif.ev_valid === 1'b1) begin
                nev2++;
                if (bif.ev_btn !== 3'd2 || bif.ev_kind !== 2'd0) good = 0;
            end
        end
        if (nev2 != 1 || !good) begin
            errors++;
            $display("FAIL hold_repress: got %0d events (fields ok=%0d) want 1 short on button 2", nev2, good);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        int nev = 0;
        rst_n = 1; btn = '0; tick();
        rst_n = 0; bif.ev_ready = 0; tick();
        btn[3] = 1;
        repeat (110) tick();
        if (bif.ev_valid !== 1'b1 || bif.ev_btn !== 3'd3 || bif.ev_kind !== 2'd1) begin
            errors++;
            $display("FAIL mid_long: got v=%b b=%0d k=%0d want v=1 b=3 k=1", bif.ev_valid, bif.ev_btn, bif.ev_kind);
        end
        checks++;
        rst_n = 1; tick();
        if (bif.ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got v=%b want v=0", bif.ev_valid);
        end
        checks++;
        rst_n = 0; bif.ev_ready = 1;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (bif.ev_valid === 1'b1 || bif.ev_drop === 1'b1) nev++;
        end
        if (nev != 0) begin
            errors++;
            $display("FAIL mid_after: got %0d event cycles want 0", nev);
        end
        checks++;
        btn = '0; tick();
    endtask

    task automatic test_random();
        int rem[NB];
        for (int i = 0; i < NB; i++) rem[i] = $urandom_range(0, 5);
        rst_n = 1; btn = '0; tick();
        rst_n = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NB; i++) begin
                if (rem[i] == 0) begin
                    btn[i] = ~btn[i];
                    rem[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(90, 180)) : int'($urandom_range(1, 12));
                end else rem[i]--;
            end
            rst_n = ($urandom_range(0, 599) == 0);
            bif.ev_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (bif.ev_valid !== m_valid || bif.ev_drop !== m_drop || (m_valid && (bif.ev_btn !== m_btn || bif.ev_kind !== m_kind))) begin
                errors++;
                $display("FAIL random_model t=%0t got v=%b b=%0d k=%0d d=%b want v=%b b=%0d k=%0d d=%b", $time, bif.ev_valid, bif.ev_btn, bif.ev_kind, bif.ev_drop, m_valid, m_btn, m_kind, m_drop);
            end
            checks++;
        end
        rst_n = 0;
    endtask

    initial begin
        rst_n = 1; btn = '0; bif.ev_ready = 0;
        test_reset();
        test_short();
        test_long();
        test_round_robin();
        test_backpressure();
        test_reset_hold();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/button_ctrl.md
BUTTON_CTRL -- requirements
Module: button_ctrl

Interface
REQ-001 SHALL have parameter N_BTN, default 4: number of debounced button inputs (2..8).
REQ-002 SHALL have parameter LONG_CNT, default 100: press length in clk cycles that qualifies as a long press (>=2).
REQ-003 SHALL have parameter REPEAT_CNT, default 25: auto-repeat interval in clk cycles after a long press (>=2).
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-high (asserted when 1).
REQ-006 SHALL have port btn_db  input  N_BTN  debounced button levels from the debounce instances, 1 = pressed.
REQ-007 SHALL have port ev_valid  output  1  event available.
REQ-008 SHALL have port ev_ready  input  1  consumer accepts the event this cycle.
REQ-009 SHALL have port ev_btn  output  3  index of the button owning the event.
REQ-010 SHALL have port ev_kind  output  2  event type: 0 short, 1 long, 2 repeat; 3 never driven.
REQ-011 SHALL have port ev_drop  output  1  one-cycle pulse when an event is lost.

Function
REQ-012 SHALL run one FSM per button with states IDLE, PRESSED, HELD.
REQ-013 IDLE -> PRESSED only on a rising edge of btn_db[i] (previous sample 0, current 1); hold counter cleared to 0.
REQ-014 PRESSED: counter increments by 1 each cycle while pressed; at counter == LONG_CNT-1 with button still pressed, SHALL raise a long event and go to HELD with counter cleared.
REQ-015 PRESSED with btn_db[i]=0: raise a short event, go to IDLE.
REQ-016 HELD: counter increments; at counter == REPEAT_CNT-1, raise a repeat event and clear counter; release -> IDLE with no event.
REQ-017 Hold counter SHALL be 16 bits; LONG_CNT and REPEAT_CNT SHALL fit in 16 bits.
REQ-018 Each button SHALL have one pending slot (flag + kind); a raised event sets it on the next clock edge.
REQ-019 An event raised while that button's slot is still pending SHALL be discarded and ev_drop pulsed for one cycle; the older pending event is kept.
REQ-020 The output register SHALL load when ev_valid=0 or ev_ready=1, taking one pending slot chosen round-robin, starting from the index after the last granted button; that slot clears in the same edge.
REQ-021 Latency SHALL be 2 cycles from the detecting cycle to ev_valid=1 when the output register is free and no other slot is pending.
REQ-022 While ev_valid=1 and ev_ready=0, ev_valid, ev_btn and ev_kind SHALL stay stable.
REQ-023 ev_ready=1 with a pending slot SHALL give back-to-back events, one per cycle; with none pending, ev_valid SHALL fall on the next edge.
REQ-024 A slot that is set and granted in the same edge SHALL be impossible; a new event sets the slot first and is granted on a later edge.

Reset
REQ-025 While rst_n=1 at a clock edge: all FSMs IDLE, counters 0, slots clear, round-robin pointer 0 (button 0 first), ev_valid=0, ev_btn=0, ev_kind=0, ev_drop=0.
REQ-026 Previous-sample registers SHALL reset to all ones, so a button held through reset generates nothing until it is released and pressed again.
REQ-027 Reset asserted mid-press or mid-handshake SHALL discard all in-flight and pending events without a drop pulse.

Configuration
REQ-028 Macro BUTTON_CTRL_REPEAT_EN defined: HELD emits repeat events per REQ-016.
REQ-029 Macro undefined: HELD emits no events and its counter is held at 0; ev_kind never equals 2; all other behaviour is identical.

Verification
REQ-030 btn_db[0] high for 10 cycles then low, ev_ready=1 -> exactly one event: ev_btn=0, ev_kind=0, 2 cycles after the release cycle.
REQ-031 btn_db[1] high for 160 cycles, REPEAT_EN defined -> long event at hold cycle 100, then repeats at hold cycles 125 and 150; nothing on release. Without the macro: long event only.
REQ-032 btn_db[0], btn_db[2] and btn_db[3] short-pressed and released in the same cycle, ev_ready=1 -> events for buttons 0, 2, 3 on consecutive cycles; a repeat of the same pattern is served in order 0, 2, 3 from the updated pointer.
REQ-033 ev_ready=0, two short presses on button 1 -> first event held stable on the outputs; second press's event pending; third press -> ev_drop pulse; after ev_ready=1, exactly two events.
REQ-034 btn_db[2] high before and during rst_n=1, then rst_n=0 with button still held for 200 cycles -> no events; release and press again for 5 cycles -> one short event.
REQ-035 rst_n=1 for one cycle while ev_valid=1 and the button is in HELD -> ev_valid=0 on the next edge; no further events until a new rising edge.
